// File: rtl/ifetch_pkg.sv
// Shared types and sizing for the instruction-fetch sequencer.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned COUNT_W    = $clog2(FIFO_DEPTH + 1);
    // Outstanding words = buffered + one in flight, so needs to hold FIFO_DEPTH+1.
    localparam int unsigned CREDIT_W   = $clog2(FIFO_DEPTH + 2);

endpackage

// File: rtl/ifetch_fifo2.sv
// Two-entry {pc,instr} FIFO with flush; entry 0 is always the head.
module ifetch_fifo2
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [DATA_W-1:0]  push_instr,
    output logic [COUNT_W-1:0] count,
    output logic               head_valid,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [DATA_W-1:0]  head_instr
);

    logic [COUNT_W-1:0] count_q;
    logic [ADDR_W-1:0]  pc0_q, pc1_q;
    logic [DATA_W-1:0]  instr0_q, instr1_q;

    // Shift-style storage: a pop moves entry 1 down so the head never needs a pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            instr0_q <= '0;
            instr1_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == COUNT_W'(0)) begin
                        pc0_q    <= push_pc;
                        instr0_q <= push_instr;
                    end else begin
                        pc1_q    <= push_pc;
                        instr1_q <= push_instr;
                    end
                    count_q <= count_q + COUNT_W'(1);
                end
                2'b01: begin
                    pc0_q    <= pc1_q;
                    instr0_q <= instr1_q;
                    count_q  <= count_q - COUNT_W'(1);
                end
                2'b11: begin
                    if (count_q == COUNT_W'(FIFO_DEPTH)) begin
                        pc0_q    <= pc1_q;
                        instr0_q <= instr1_q;
                        pc1_q    <= push_pc;
                        instr1_q <= push_instr;
                    end else begin
                        pc0_q    <= push_pc;
                        instr0_q <= push_instr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != COUNT_W'(0));
    assign head_pc    = pc0_q;
    assign head_instr = instr0_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && count_q == COUNT_W'(FIFO_DEPTH)));

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC, IMEM issue with credit flow control, redirect/flush.
// Optional halt-on-HALT_WORD detection is enabled by defining IFETCH_HALT_DETECT_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
    input  logic              IFETCH_clk,
    input  logic              IFETCH_rst,
    input  logic              IFETCH_start,
    output logic [ADDR_W-1:0] IFETCH_imem_addr,
    input  logic [DATA_W-1:0] IFETCH_imem_instr,
    input  logic              IFETCH_redirect,
    input  logic [ADDR_W-1:0] IFETCH_redirect_pc,
    output logic              IFETCH_out_valid,
    input  logic              IFETCH_out_ready,
    output logic [DATA_W-1:0] IFETCH_out_instr,
    output logic [ADDR_W-1:0] IFETCH_out_pc,
    output logic              IFETCH_busy,
    output logic              IFETCH_halted
);

`ifdef IFETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  inflight_pc_q;
    logic               inflight_q;
    logic               busy_q;
    logic               halted_q;

    logic [COUNT_W-1:0]  fifo_count;
    logic [CREDIT_W-1:0] credit_c;
    logic pop_c, push_c, issue_c, redirect_c, halt_hit_c;

    assign pop_c      = IFETCH_out_valid & IFETCH_out_ready;
    assign redirect_c = IFETCH_redirect && !(HALT_EN && state_q == HALT);
    assign push_c     = inflight_q && !redirect_c;
    assign halt_hit_c = HALT_EN && push_c && (IFETCH_imem_instr == HALT_WORD);

    // Words already owed to the FIFO after this edge's pop; a slot must remain for a new read.
    assign credit_c = CREDIT_W'(fifo_count) + CREDIT_W'(inflight_q) - CREDIT_W'(pop_c);
    assign issue_c  = (state_q == RUN) && !redirect_c && !halt_hit_c
                    && (credit_c < CREDIT_W'(FIFO_DEPTH));

    always_ff @(posedge IFETCH_clk or posedge IFETCH_rst) begin
        if (IFETCH_rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (IFETCH_start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt_hit_c) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                HALT: ;
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (redirect_c) begin
                pc_q <= IFETCH_redirect_pc;
            end else if (issue_c) begin
                pc_q <= pc_q + ADDR_W'(1);
            end

            inflight_q <= issue_c;
            if (issue_c) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    ifetch_fifo2 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (IFETCH_clk),
        .rst        (IFETCH_rst),
        .push       (push_c),
        .pop        (pop_c),
        .flush      (redirect_c),
        .push_pc    (inflight_pc_q),
        .push_instr (IFETCH_imem_instr),
        .count      (fifo_count),
        .head_valid (IFETCH_out_valid),
        .head_pc    (IFETCH_out_pc),
        .head_instr (IFETCH_out_instr)
    );

    assign IFETCH_imem_addr = pc_q;
    assign IFETCH_busy      = busy_q;
    assign IFETCH_halted    = halted_q;

endmodule
